// File: rtl/dlx_pkg.sv
// Shared encodings for the DLX fetch slice: NOP, TRAP opcode, opcode field and fetch states.
package dlx_pkg;

  localparam logic [31:0] NOP     = 32'h0000_0000;
  localparam logic [5:0]  OP_TRAP = 6'b010001;
  localparam int          OP_MSB  = 31;
  localparam int          OP_LSB  = 26;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  function automatic logic is_trap(input logic [31:0] inst);
    return inst[OP_MSB:OP_LSB] == OP_TRAP;
  endfunction

endpackage

// File: rtl/dlx_if_id_reg.sv
// IF/ID pipeline register; a bubble request wins over a load, neither means hold.
module dlx_if_id_reg
  import dlx_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [31:0]       inst_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] pc_o,
  output logic              valid_o
);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      inst_o  <= NOP;
      pc_o    <= '0;
      valid_o <= 1'b0;
    end else if (bubble_i) begin
      inst_o  <= NOP;
      pc_o    <= '0;
      valid_o <= 1'b0;
    end else if (load_i) begin
      inst_o  <= inst_i;
      pc_o    <= pc_i;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: rtl/dlx_fetch_unit.sv
// DLX instruction fetch: BOOT/RUN/HALT sequencer driving the ROM address and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt_o, a count of valid IF/ID loads.
module dlx_fetch_unit
  import dlx_pkg::*;
#(
  parameter int          ADDR_W   = 6,
  parameter int unsigned PC_RESET = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o,
  output logic        valid_o,
`ifdef FETCH_PERF_CNT_EN
  output logic        halted_o,
  output logic [31:0] fetch_cnt_o
`else
  output logic        halted_o
`endif
);

  localparam logic [ADDR_W-1:0] PC_RST = PC_RESET[ADDR_W-1:0];

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] ifid_pc;
  logic              load, bubble;
  logic              unused_redirect_hi;

  assign unused_redirect_hi = ^redirect_pc_i[31:ADDR_W];

  // Redirect overrides stall and any TRAP seen in the same cycle.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    bubble  = 1'b0;
    if (redirect_i) begin
      state_d = ST_RUN;
      pc_d    = redirect_pc_i[ADDR_W-1:0];
      bubble  = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (!stall_i) begin
            load = 1'b1;
            if (is_trap(rom_data_i)) state_d = ST_HALT;
            else                     pc_d    = pc_q + ADDR_W'(1);
          end
        end
        ST_HALT: bubble = !stall_i;
        default: state_d = ST_BOOT;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_RST;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  dlx_if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (load),
    .bubble_i (bubble),
    .inst_i   (rom_data_i),
    .pc_i     (pc_q),
    .inst_o   (inst_o),
    .pc_o     (ifid_pc),
    .valid_o  (valid_o)
  );

  assign rom_addr_o = 32'(pc_q);
  assign pc_o       = 32'(ifid_pc);
  assign npc_o      = 32'(ADDR_W'(ifid_pc + ADDR_W'(1)));
  assign halted_o   = (state_q == ST_HALT);

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)                 fetch_cnt_q <= '0;
    else if (load && !bubble)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
  end

  assign fetch_cnt_o = fetch_cnt_q;
`endif

endmodule

// File: tb/tb_dlx_fetch_unit.sv
// Directed bench for dlx_fetch_unit with a behavioural ROM and an expected-fetch scoreboard.
module tb_dlx_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;

  logic        clk = 1'b0;
  logic        rst_n, stall, redir;
  logic [31:0] rpc, rom_addr, rom_data, inst, pc, npc;
  logic        valid, halted;
  logic [31:0] rom [64];
  fetch_t      sb [$];
  int          errors = 0;
  int          checks = 0;
  int          nexp   = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
`endif

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr[5:0]];

  dlx_fetch_unit dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .rom_addr_o    (rom_addr),
    .rom_data_i    (rom_data),
    .inst_o        (inst),
    .pc_o          (pc),
    .npc_o         (npc),
    .valid_o       (valid),
`ifdef FETCH_PERF_CNT_EN
    .halted_o      (halted),
    .fetch_cnt_o   (fetch_cnt)
`else
    .halted_o      (halted)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int a);
    fetch_t f;
    f.pc   = 32'(a);
    f.inst = rom[a];
    sb.push_back(f);
  endtask

  task automatic pop_chk(input string tag);
    fetch_t f;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    f = sb.pop_front();
    nexp++;
    chk({tag, "_valid"}, 32'(valid), 32'd1);
    chk({tag, "_pc"},    pc,         f.pc);
    chk({tag, "_inst"},  inst,       f.inst);
    chk({tag, "_npc"},   npc,        (f.pc + 32'd1) % 32'd64);
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_bub_valid"}, 32'(valid), 32'd0);
    chk({tag, "_bub_inst"},  inst,       32'd0);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; redir = 1'b0; rpc = '0;
    for (int i = 0; i < 64; i++) rom[i] = {6'b001000, 26'(i * 3 + 1)};
    #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_npc", npc, 32'd1);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_romaddr", rom_addr, 32'd0);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("boot_romaddr", rom_addr, 32'd0);
    tick();
    chk_bubble("boot");
    chk("boot_romaddr_run", rom_addr, 32'd0);
    for (int p = 0; p < 4; p++) begin
      push(p);
      tick();
      pop_chk("seq");
      chk("seq_romaddr", rom_addr, 32'(p + 1));
    end

    // Stall while pc_o = 3
    stall = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("stall_valid", 32'(valid), 32'd1);
      chk("stall_pc", pc, 32'd3);
      chk("stall_inst", inst, rom[3]);
      chk("stall_romaddr", rom_addr, 32'd4);
    end
    stall = 1'b0;
    push(4); tick(); pop_chk("unstall");

    // Redirect with simultaneous stall
    redir = 1'b1; rpc = 32'h20; stall = 1'b1;
    tick();
    redir = 1'b0; stall = 1'b0;
    chk_bubble("redir");
    chk("redir_romaddr", rom_addr, 32'h20);
    push(32'h20); tick(); pop_chk("redir_first");

    // Wrap; upper redirect bits ignored
    redir = 1'b1; rpc = 32'hFFFF_FFFE;
    tick();
    redir = 1'b0;
    chk_bubble("wrap_redir");
    chk("wrap_romaddr", rom_addr, 32'd62);
    push(62); tick(); pop_chk("wrap62");
    push(63); tick(); pop_chk("wrap63");
    push(0);  tick(); pop_chk("wrap0");

    // TRAP at address 5
    rom[5] = {6'b010001, 26'h5};
    redir = 1'b1; rpc = 32'd3;
    tick();
    redir = 1'b0;
    chk_bubble("trap_redir");
    push(3); tick(); pop_chk("trap3");
    push(4); tick(); pop_chk("trap4");
    push(5); tick(); pop_chk("trap5");
    chk("trap_halted", 32'(halted), 32'd1);
    chk("trap_romaddr", rom_addr, 32'd5);
    tick();
    chk_bubble("halt1");
    chk("halt1_halted", 32'(halted), 32'd1);
    chk("halt1_romaddr", rom_addr, 32'd5);
    stall = 1'b1;
    tick();
    stall = 1'b0;
    chk_bubble("halt_stall");
    chk("halt_stall_halted", 32'(halted), 32'd1);
    redir = 1'b1; rpc = 32'h10;
    tick();
    redir = 1'b0;
    chk_bubble("unhalt");
    chk("unhalt_halted", 32'(halted), 32'd0);
    chk("unhalt_romaddr", rom_addr, 32'h10);
    push(32'h10); tick(); pop_chk("unhalt_first");

    // Redirect beats a TRAP being captured in the same cycle
    redir = 1'b1; rpc = 32'd4;
    tick();
    redir = 1'b0;
    push(4); tick(); pop_chk("tr_pre");
    redir = 1'b1; rpc = 32'd8;
    tick();
    redir = 1'b0;
    chk_bubble("tr_redir");
    chk("tr_halted", 32'(halted), 32'd0);
    chk("tr_romaddr", rom_addr, 32'd8);
    push(8); tick(); pop_chk("tr_after");
`ifdef FETCH_PERF_CNT_EN
    chk("perf_cnt", fetch_cnt, 32'(nexp));
`endif

    // Asynchronous reset mid-operation
    redir = 1'b1; rpc = 32'h12;
    tick();
    redir = 1'b0;
    push(32'h12); tick(); pop_chk("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_inst", inst, 32'd0);
    chk("arst_pc", pc, 32'd0);
    chk("arst_halted", 32'(halted), 32'd0);
    chk("arst_romaddr", rom_addr, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("arst_cnt", fetch_cnt, 32'd0);
`endif
    sb.delete();
    nexp = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    chk_bubble("reboot");
    push(0); tick(); pop_chk("reboot_first");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
